zbus_master: RTL and testbench

//  Synthesisable Z80 bus-cycle master: replays queued memory/IO read/write commands onto the ZX bus
//  (za/zd/zmreq_n/ziorq_n/zrd_n/zwr_n) with Z80 T-state timing, one T-state per clk.

---
 rtl/zbus_pkg.sv | 35 +++
 rtl/zbus_if.sv | 36 +++
 rtl/zbus_cmd_fifo.sv | 64 ++++++
 rtl/zbus_master.sv | 182 ++++++++++++++++++
 tb/tb_zbus_master.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/zbus_pkg.sv
// zbus_pkg: shared definitions for the Z80 bus-cycle master.
// Contains the command op encodings, the bus-cycle state enum, field widths and op decode helpers.
package zbus_pkg;

    localparam int OP_W   = 2;
    localparam int ADDR_W = 16;
    localparam int DATA_W = 8;
    localparam int CMD_W  = OP_W + ADDR_W + DATA_W;

    localparam logic [OP_W-1:0] OP_MEMRD = 2'b00;
    localparam logic [OP_W-1:0] OP_MEMWR = 2'b01;
    localparam logic [OP_W-1:0] OP_IORD  = 2'b10;
    localparam logic [OP_W-1:0] OP_IOWR  = 2'b11;

    // Wait-state counter width: fixed TW counts run 0..7
    localparam int              TW_W   = 3;
    localparam logic [TW_W-1:0] TW_ONE = 3'd1;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_T1   = 3'd1,
        ST_T2   = 3'd2,
        ST_TW   = 3'd3,
        ST_T3   = 3'd4
    } zbus_state_e;

    function automatic logic op_is_io(input logic [OP_W-1:0] op);
        return (op == OP_IORD) || (op == OP_IOWR);
    endfunction

    function automatic logic op_is_wr(input logic [OP_W-1:0] op);
        return (op == OP_MEMWR) || (op == OP_IOWR);
    endfunction

endpackage

// File: rtl/zbus_if.sv
// zbus_if: command/response handshake plus the ZX-side bus pins of zbus_master.
// master modport is the bus-cycle engine; slave modport is whoever feeds commands and models the bus.
interface zbus_if;
    import zbus_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    logic [OP_W-1:0]   cmd_op;
    logic [ADDR_W-1:0] cmd_addr;
    logic [DATA_W-1:0] cmd_wdata;
    logic              rsp_valid;
    logic [DATA_W-1:0] rsp_rdata;
    logic              busy;
    logic [ADDR_W-1:0] za;
    logic [DATA_W-1:0] zd_out;
    logic              zd_oe;
    logic [DATA_W-1:0] zd_in;
    logic              zmreq_n;
    logic              ziorq_n;
    logic              zrd_n;
    logic              zwr_n;
    logic              zwait_n;

    modport master (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, zd_in, zwait_n,
        output cmd_ready, rsp_valid, rsp_rdata, busy, za, zd_out, zd_oe,
               zmreq_n, ziorq_n, zrd_n, zwr_n
    );

    modport slave (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, zd_in, zwait_n,
        input  cmd_ready, rsp_valid, rsp_rdata, busy, za, zd_out, zd_oe,
               zmreq_n, ziorq_n, zrd_n, zwr_n
    );

endinterface

// File: rtl/zbus_cmd_fifo.sv
// zbus_cmd_fifo: synchronous command FIFO {op, addr, wdata}.
// A push while full is accepted only when a pop happens in the same clock.
module zbus_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 26,
    parameter int CW    = $clog2(DEPTH) + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] din,
    input  logic             pop,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty,
    output logic [CW-1:0]    count
);
    localparam int              AW      = $clog2(DEPTH);
    localparam logic [AW-1:0]   PTR_ONE = AW'(1);
    localparam logic [CW-1:0]   CNT_ONE = CW'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [AW-1:0]    wr_ptr_r;
    logic [AW-1:0]    rd_ptr_r;
    logic [CW-1:0]    count_r;
    logic             push_ok_s;
    logic             pop_ok_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == '0);
    assign count     = count_r;
    assign dout      = mem_r[rd_ptr_r];
    assign pop_ok_s  = pop && !empty;
    assign push_ok_s = push && (!full || pop_ok_s);

    // Storage array write; contents need no reset because count gates visibility
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally since DEPTH is a power of 2
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            count_r  <= '0;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + PTR_ONE;
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({push_ok_s, pop_ok_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/zbus_master.sv
// zbus_master: replays queued memory/IO read/write commands as Z80 bus cycles,
// one T-state per clk: IDLE -> T1 -> T2 -> TW* -> T3 -> (T1 | IDLE).
// Optional feature macro ZBUS_WAIT_EN: zwait_n stretches the cycle with extra TW states.
module zbus_master
    import zbus_pkg::*;
#(
    parameter int CMD_DEPTH = 4,
    parameter int MEM_TW    = 0,
    parameter int IO_TW     = 1
) (
    input  logic   clk,
    input  logic   rst,
    zbus_if.master bus
);
    localparam int              CNT_W    = $clog2(CMD_DEPTH) + 1;
    localparam logic [TW_W-1:0] MEM_TW_C = TW_W'(MEM_TW);
    localparam logic [TW_W-1:0] IO_TW_C  = TW_W'(IO_TW);

    logic              fifo_push_s;
    logic              fifo_pop_s;
    logic              fifo_full_s;
    logic              fifo_empty_s;
    logic [CMD_W-1:0]  fifo_din_s;
    logic [CMD_W-1:0]  fifo_dout_s;
    logic [CNT_W-1:0]  fifo_count_s;
    logic [OP_W-1:0]   head_op_s;
    logic [ADDR_W-1:0] head_addr_s;
    logic [DATA_W-1:0] head_wdata_s;
    logic [TW_W-1:0]   tw_len_s;
    logic              wait_low_s;

    zbus_state_e       state_r;
    logic [OP_W-1:0]   op_r;
    logic [TW_W-1:0]   tw_cnt_r;
    logic [ADDR_W-1:0] za_r;
    logic [DATA_W-1:0] zd_out_r;
    logic              zd_oe_r;
    logic              zmreq_n_r;
    logic              ziorq_n_r;
    logic              zrd_n_r;
    logic              zwr_n_r;
    logic              rsp_valid_r;
    logic [DATA_W-1:0] rsp_rdata_r;

    assign fifo_din_s   = {bus.cmd_op, bus.cmd_addr, bus.cmd_wdata};
    assign fifo_push_s  = bus.cmd_valid && !fifo_full_s;
    // The head is consumed only when a new bus cycle is launched
    assign fifo_pop_s   = !fifo_empty_s && ((state_r == ST_IDLE) || (state_r == ST_T3));
    assign head_op_s    = fifo_dout_s[CMD_W-1 -: OP_W];
    assign head_addr_s  = fifo_dout_s[DATA_W +: ADDR_W];
    assign head_wdata_s = fifo_dout_s[DATA_W-1:0];
    assign tw_len_s     = op_is_io(op_r) ? IO_TW_C : MEM_TW_C;

`ifdef ZBUS_WAIT_EN
    assign wait_low_s = ~bus.zwait_n;
`else
    logic unused_zwait_s;
    assign unused_zwait_s = bus.zwait_n;
    assign wait_low_s     = 1'b0;
`endif

    zbus_cmd_fifo #(
        .DEPTH (CMD_DEPTH),
        .WIDTH (CMD_W),
        .CW    (CNT_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (fifo_push_s),
        .din   (fifo_din_s),
        .pop   (fifo_pop_s),
        .dout  (fifo_dout_s),
        .full  (fifo_full_s),
        .empty (fifo_empty_s),
        .count (fifo_count_s)
    );

    // Bus-cycle sequencer: state, strobes, address/data drivers and read response
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r     <= ST_IDLE;
            op_r        <= OP_MEMRD;
            tw_cnt_r    <= '0;
            za_r        <= 16'h0000;
            zd_out_r    <= 8'h00;
            zd_oe_r     <= 1'b0;
            zmreq_n_r   <= 1'b1;
            ziorq_n_r   <= 1'b1;
            zrd_n_r     <= 1'b1;
            zwr_n_r     <= 1'b1;
            rsp_valid_r <= 1'b0;
            rsp_rdata_r <= 8'h00;
        end else begin
            rsp_valid_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (!fifo_empty_s) begin
                        state_r <= ST_T1;
                        op_r    <= head_op_s;
                        za_r    <= head_addr_s;
                        if (op_is_wr(head_op_s)) begin
                            zd_out_r <= head_wdata_s;
                            zd_oe_r  <= 1'b1;
                        end
                    end
                end
                ST_T1: begin
                    // Data drive also covers a write whose T1 had to keep the bus released
                    state_r <= ST_T2;
                    zd_oe_r <= op_is_wr(op_r);
                    if (op_is_io(op_r)) begin
                        ziorq_n_r <= 1'b0;
                    end else begin
                        zmreq_n_r <= 1'b0;
                    end
                    if (op_is_wr(op_r)) begin
                        zwr_n_r <= 1'b0;
                    end else begin
                        zrd_n_r <= 1'b0;
                    end
                end
                ST_T2: begin
                    if (tw_len_s != '0) begin
                        state_r  <= ST_TW;
                        tw_cnt_r <= tw_len_s - TW_ONE;
                    end else if (wait_low_s) begin
                        state_r  <= ST_TW;
                        tw_cnt_r <= '0;
                    end else begin
                        state_r  <= ST_T3;
                    end
                end
                ST_TW: begin
                    // tw_cnt_r counts fixed TWs still to come; WAIT only matters on the last one
                    if (tw_cnt_r != '0) begin
                        tw_cnt_r <= tw_cnt_r - TW_ONE;
                    end else if (!wait_low_s) begin
                        state_r <= ST_T3;
                    end
                end
                ST_T3: begin
                    // Release the bus for at least one clk; a queued command starts its T1 immediately
                    zmreq_n_r <= 1'b1;
                    ziorq_n_r <= 1'b1;
                    zrd_n_r   <= 1'b1;
                    zwr_n_r   <= 1'b1;
                    zd_oe_r   <= 1'b0;
                    if (!op_is_wr(op_r)) begin
                        rsp_valid_r <= 1'b1;
                        rsp_rdata_r <= bus.zd_in;
                    end
                    if (!fifo_empty_s) begin
                        state_r <= ST_T1;
                        op_r    <= head_op_s;
                        za_r    <= head_addr_s;
                        if (op_is_wr(head_op_s)) begin
                            zd_out_r <= head_wdata_s;
                        end
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = ~fifo_full_s;
    assign bus.busy      = (state_r != ST_IDLE) || (fifo_count_s != '0);
    assign bus.za        = za_r;
    assign bus.zd_out    = zd_out_r;
    assign bus.zd_oe     = zd_oe_r;
    assign bus.zmreq_n   = zmreq_n_r;
    assign bus.ziorq_n   = ziorq_n_r;
    assign bus.zrd_n     = zrd_n_r;
    assign bus.zwr_n     = zwr_n_r;
    assign bus.rsp_valid = rsp_valid_r;
    assign bus.rsp_rdata = rsp_rdata_r;

endmodule

// File: tb/tb_zbus_master.sv
// tb_zbus_master: randomized and directed bench for zbus_master.
// Reference model: every accepted command is laid out as a per-clock timeline of expected bus values.
// With ZBUS_WAIT_EN defined, also exercises WAIT-stretched cycles.
module tb_zbus_master;
    import zbus_pkg::*;

    localparam int DEPTH  = 4;
    localparam int MEM_TW = 0;
    localparam int IO_TW  = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;

    zbus_if bus();

    zbus_master #(
        .CMD_DEPTH (DEPTH),
        .MEM_TW    (MEM_TW),
        .IO_TW     (IO_TW)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit          act;
        bit          ld;
        bit          wr;
        bit          rd_end;
        bit          mreq_n;
        bit          iorq_n;
        bit          rd_n;
        bit          wr_n;
        bit          oe;
        bit          wait_n;
        logic [15:0] za;
        logic [7:0]  wd;
    } exp_t;

    exp_t        tl [int];
    int          pend[$];
    int          cyc, next_free, last_end, last_start, rsp_cyc, next_extra;
    logic [15:0] za_m;
    logic [7:0]  zd_m, rdata_m, rd_next;
    int          n_vec, n_err;
    int          lo_mreq, lo_iorq, lo_rd, lo_wr, lo_oe, n_notready;
    bit          acc_g;
    bit          fix_en;
    logic [7:0]  fix_val;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic exp_t idle_e();
        exp_t e;
        e.act = 0; e.ld = 0; e.wr = 0; e.rd_end = 0;
        e.mreq_n = 1; e.iorq_n = 1; e.rd_n = 1; e.wr_n = 1;
        e.oe = 0; e.wait_n = 1; e.za = 16'h0000; e.wd = 8'h00;
        return e;
    endfunction

    task automatic clear_model();
        tl.delete();
        pend.delete();
        next_free = 0;
        last_end  = -100;
        rsp_cyc   = -1;
        za_m      = 16'h0000;
        zd_m      = 8'h00;
        rdata_m   = 8'h00;
    endtask

    task automatic clr_cnt();
        lo_mreq = 0; lo_iorq = 0; lo_rd = 0; lo_wr = 0; lo_oe = 0; n_notready = 0;
    endtask

    // Lay out one command accepted at edge a: T1, T2, TWs (fixed + extra WAIT), T3
    task automatic schedule(input logic [1:0] op, input logic [15:0] ad, input logic [7:0] wd,
                            input int a, input int extra);
        int   tw, len, st, en;
        bit   bb, is_io, is_wr;
        exp_t e;
        is_io = (op == OP_IORD) || (op == OP_IOWR);
        is_wr = (op == OP_MEMWR) || (op == OP_IOWR);
        tw    = is_io ? IO_TW : MEM_TW;
        len   = 3 + tw + extra;
        st    = (a + 1 > next_free) ? a + 1 : next_free;
        en    = st + len - 1;
        bb    = (st == last_end + 1);
        for (int k = st; k <= en; k++) begin
            e = idle_e();
            e.act = 1;
            if (k == st) begin
                e.ld = 1; e.za = ad; e.wd = wd; e.wr = is_wr;
            end else begin
                if (is_io) e.iorq_n = 0; else e.mreq_n = 0;
                if (is_wr) e.wr_n = 0;   else e.rd_n = 0;
            end
            e.oe     = is_wr && !(k == st && bb);
            e.rd_end = (k == en) && !is_wr;
            if (extra > 0 && k >= st + 1 + tw && k <= st + tw + extra) e.wait_n = 0;
            tl[k] = e;
        end
        pend.push_back(st);
        next_free  = en + 1;
        last_end   = en;
        last_start = st;
    endtask

    // One clock: drive bus inputs, compare all outputs mid-cycle, advance the model at the edge
    task automatic step();
        exp_t        e;
        bit          rdy_e, busy_e, acc;
        logic [1:0]  op;
        logic [15:0] ad;
        logic [7:0]  wd;
        e = idle_e();
        if (tl.exists(cyc)) e = tl[cyc];
        while (pend.size() != 0 && pend[0] <= cyc) void'(pend.pop_front());
        rdy_e  = (pend.size() < DEPTH);
        busy_e = (pend.size() != 0) || e.act;
        if (e.ld) begin
            za_m = e.za;
            if (e.wr) zd_m = e.wd;
        end
        if (cyc == rsp_cyc) rdata_m = rd_next;
        bus.zd_in = fix_en ? fix_val : 8'($urandom);
`ifdef ZBUS_WAIT_EN
        bus.zwait_n = e.wait_n;
`else
        bus.zwait_n = 1'($urandom);
`endif
        #3;
        chk("za",        bus.za,        za_m);
        chk("zd_out",    bus.zd_out,    zd_m);
        chk("zd_oe",     bus.zd_oe,     e.oe);
        chk("zmreq_n",   bus.zmreq_n,   e.mreq_n);
        chk("ziorq_n",   bus.ziorq_n,   e.iorq_n);
        chk("zrd_n",     bus.zrd_n,     e.rd_n);
        chk("zwr_n",     bus.zwr_n,     e.wr_n);
        chk("cmd_ready", bus.cmd_ready, rdy_e);
        chk("busy",      bus.busy,      busy_e);
        chk("rsp_valid", bus.rsp_valid, (cyc == rsp_cyc));
        chk("rsp_rdata", bus.rsp_rdata, rdata_m);
        if (bus.zmreq_n === 1'b0)   lo_mreq++;
        if (bus.ziorq_n === 1'b0)   lo_iorq++;
        if (bus.zrd_n === 1'b0)     lo_rd++;
        if (bus.zwr_n === 1'b0)     lo_wr++;
        if (bus.zd_oe === 1'b1)     lo_oe++;
        if (bus.cmd_ready === 1'b0) n_notready++;
        if (e.rd_end) begin
            rsp_cyc = cyc + 1;
            rd_next = bus.zd_in;
        end
        acc = bus.cmd_valid && rdy_e && !rst;
        op  = bus.cmd_op;
        ad  = bus.cmd_addr;
        wd  = bus.cmd_wdata;
        @(posedge clk);
        if (rst) begin
            clear_model();
        end else if (acc) begin
            schedule(op, ad, wd, cyc + 1, next_extra);
            next_extra = 0;
        end
        acc_g = acc;
        cyc++;
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_one(input logic [1:0] op, input logic [15:0] ad, input logic [7:0] wd);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = ad;
        bus.cmd_wdata = wd;
        acc_g = 0;
        for (int i = 0; i < 60 && !acc_g; i++) step();
        bus.cmd_valid = 1'b0;
        chk("push_accept", acc_g, 1'b1);
    endtask

    initial begin
        int s0;
        n_vec = 0; n_err = 0; cyc = 0; next_extra = 0; fix_en = 0; fix_val = 8'h00;
        bus.cmd_valid = 1'b0; bus.cmd_op = OP_MEMRD; bus.cmd_addr = 16'h0000;
        bus.cmd_wdata = 8'h00; bus.zd_in = 8'h00; bus.zwait_n = 1'b1;
        clear_model();
        clr_cnt();
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // Reset state
        idle(2);

        // Memory write, no wait states
        clr_cnt();
        push_one(OP_MEMWR, 16'h1234, 8'hAB);
        idle(6);
        chk("memwr_mreq_clks", lo_mreq, 2);
        chk("memwr_wr_clks",   lo_wr,   2);
        chk("memwr_oe_clks",   lo_oe,   3);

        // Memory read with fixed bus data
        clr_cnt();
        fix_en = 1; fix_val = 8'h5A;
        push_one(OP_MEMRD, 16'h1111, 8'h00);
        idle(6);
        fix_en = 0;
        chk("memrd_mreq_clks", lo_mreq, 2);
        chk("memrd_rd_clks",   lo_rd,   2);
        chk("memrd_rdata",     bus.rsp_rdata, 8'h5A);

        // IO write and IO read with the automatic TW
        clr_cnt();
        push_one(OP_IOWR, 16'h2222, 8'h99);
        idle(7);
        chk("iowr_iorq_clks", lo_iorq, 3);
        chk("iowr_wr_clks",   lo_wr,   3);
        chk("iowr_mreq_clks", lo_mreq, 0);
        clr_cnt();
        push_one(OP_IORD, 16'hEEEE, 8'h00);
        idle(7);
        chk("iord_iorq_clks", lo_iorq, 3);
        chk("iord_rd_clks",   lo_rd,   3);
        chk("iord_mreq_clks", lo_mreq, 0);

        // Back-to-back burst that fills the queue
        clr_cnt();
        for (int i = 0; i < DEPTH + 2; i++) begin
            push_one(2'($urandom), 16'($urandom), 8'($urandom));
        end
        idle(40);
        chk("burst_saw_full", (n_notready > 0), 1'b1);
        chk("burst_busy_end", bus.busy, 1'b0);

        // Reset during T2 of a write with two commands still queued
        push_one(OP_MEMWR, 16'hA5A5, 8'h3C);
        s0 = last_start;
        push_one(OP_MEMRD, 16'h5A5A, 8'h00);
        push_one(OP_IOWR, 16'h0F0F, 8'hC3);
        for (int i = 0; i < 20 && cyc < s0 + 1; i++) step();
        chk("rst_at_t2", cyc, s0 + 1);
        rst = 1'b1;
        step();
        rst = 1'b0;
        clr_cnt();
        idle(10);
        chk("rst_no_mreq", lo_mreq, 0);
        chk("rst_no_iorq", lo_iorq, 0);
        chk("rst_no_oe",   lo_oe,   0);

`ifdef ZBUS_WAIT_EN
        // WAIT held low for two clks from T2
        clr_cnt();
        next_extra = 2;
        push_one(OP_MEMRD, 16'h4321, 8'h00);
        idle(10);
        chk("wait_rd_clks", lo_rd, 4);
`endif

        // Randomized traffic with occasional resets
        for (int i = 0; i < 800; i++) begin
            bus.cmd_valid = ($urandom_range(0, 3) != 0);
            bus.cmd_op    = 2'($urandom);
            bus.cmd_addr  = 16'($urandom);
            bus.cmd_wdata = 8'($urandom);
            rst = ($urandom_range(0, 199) == 0);
            step();
            rst = 1'b0;
        end
        bus.cmd_valid = 1'b0;
        idle(40);
        chk("final_idle", bus.busy, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
